// File: rtl/avg_pkg.sv
// avg_pkg: shared constants, FSM state type and clog2 helper for the averaging arbiter.
package avg_pkg;

    localparam int AVG_PIPE_LAT  = 4;
    localparam int AVG_SUM_EXTRA = 4;

    typedef enum logic {IDLE, GRANT} state_e;

    // Never returns 0 so single-entry indices still get a 1-bit field.
    function automatic int clog2(input int v);
        int r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/avg_rr_pick.sv
// avg_rr_pick: combinational round-robin search for the first set request at or after ptr, with wrap.
module avg_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    localparam logic [W:0] NW = N;

    logic [2*N-1:0] dbl;
    logic [W-1:0]   off;
    logic [W:0]     sum;

    // Rotating a doubled copy puts the request at ptr in bit 0.
    assign dbl = {req, req} >> ptr;
    assign any = |req;

    always_comb begin
        off = '0;
        for (int k = N - 1; k >= 0; k--) if (dbl[k]) off = W'(k);
    end

    assign sum = {1'b0, ptr} + {1'b0, off};
    assign idx = (sum >= NW) ? W'(sum - NW) : sum[W-1:0];

endmodule

// File: rtl/avg_op_arbiter.sv
// avg_op_arbiter: round-robin, burst-limited sharing of one averaging datapath with tag-routed results.
// Optional AVG_ARB_STATS_EN adds per-channel saturating accepted-beat counters.
module avg_op_arbiter
    import avg_pkg::*;
#(
    parameter int  NUM_CH      = 4,
    parameter int  PIXEL_WIDTH = 8,
    parameter int  SUM_WIDTH   = PIXEL_WIDTH + AVG_SUM_EXTRA,
    parameter int  MAX_BURST   = 16,
    parameter int  PIPE_LAT    = AVG_PIPE_LAT,
    localparam int CH_W        = clog2(NUM_CH),
    localparam int BC_W        = clog2(MAX_BURST + 1)
) (
    input  logic                        clk,
    input  logic                        arstn,
    input  logic                        enable,
    input  logic [NUM_CH-1:0]           req_valid,
    output logic [NUM_CH-1:0]           req_ready,
    input  logic [NUM_CH*SUM_WIDTH-1:0] req_data,
    output logic                        op_din_valid,
    output logic [SUM_WIDTH-1:0]        op_din_data,
    input  logic                        op_dout_valid,
    input  logic [PIXEL_WIDTH-1:0]      op_dout_data,
    output logic [NUM_CH-1:0]           res_valid,
    output logic [PIXEL_WIDTH-1:0]      res_data,
    output logic [CH_W-1:0]             res_ch,
`ifdef AVG_ARB_STATS_EN
    input  logic                        stat_clr,
    output logic [NUM_CH*16-1:0]        stat_cnt,
`endif
    output logic                        busy,
    output logic                        tag_err
);

    state_e                          state_q, state_d;
    logic [CH_W-1:0]                 grant_q, grant_d, ptr_q, ptr_d, pick_idx;
    logic [BC_W-1:0]                 burst_q, burst_d;
    logic [SUM_WIDTH-1:0]            din_q, gdata;
    logic [PIPE_LAT-1:0]             tv_q;
    logic [PIPE_LAT-1:0][CH_W-1:0]   tc_q;
    logic                            err_q, pick_any, accept, leave, hit;

    avg_rr_pick #(.N(NUM_CH), .W(CH_W)) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign gdata = req_data[int'(grant_q)*SUM_WIDTH +: SUM_WIDTH];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        burst_d   = burst_q;
        req_ready = '0;
        accept    = 1'b0;
        leave     = 1'b0;
        if (state_q == IDLE) begin
            if (enable && pick_any) begin
                grant_d = pick_idx;
                burst_d = '0;
                state_d = GRANT;
            end
        end else begin
            req_ready[grant_q] = enable;
            accept = enable & req_valid[grant_q];
            leave  = !req_valid[grant_q] || !enable || (accept && burst_q == BC_W'(MAX_BURST - 1));
            burst_d = accept ? burst_q + 1'b1 : burst_q;
            if (leave) begin
                state_d = IDLE;
                ptr_d   = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
            end
        end
    end

    assign op_din_valid = accept;
    assign op_din_data  = accept ? gdata : din_q;

    // A result is only routed when the datapath and the tag pipe agree it exists.
    assign hit       = op_dout_valid & tv_q[PIPE_LAT-1];
    assign res_valid = hit ? (NUM_CH'(1) << tc_q[PIPE_LAT-1]) : '0;
    assign res_data  = hit ? op_dout_data : '0;
    assign res_ch    = hit ? tc_q[PIPE_LAT-1] : '0;
    assign busy      = (state_q == GRANT) | (|tv_q);
    assign tag_err   = err_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
            din_q   <= '0;
            tv_q    <= '0;
            tc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            din_q   <= op_din_data;
            tv_q[0] <= accept;
            tc_q[0] <= grant_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tv_q[i] <= tv_q[i-1];
                tc_q[i] <= tc_q[i-1];
            end
            err_q <= err_q | (op_dout_valid ^ tv_q[PIPE_LAT-1]);
        end
    end

`ifdef AVG_ARB_STATS_EN
    logic [NUM_CH-1:0][15:0] st_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            st_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (stat_clr) st_q[i] <= '0;
                else if (accept && grant_q == CH_W'(i) && st_q[i] != 16'hFFFF) st_q[i] <= st_q[i] + 1'b1;
        end
    end

    assign stat_cnt = st_q;
`endif

endmodule

// File: tb/tb_avg_op_arbiter.sv
// tb_avg_op_arbiter: directed and random stimulus for avg_op_arbiter against a transaction-level model.
module tb_avg_op_arbiter;

    localparam int N = 4, PW = 8, SW = 12, MB = 4, LAT = 4;

    logic              clk = 1'b0, arstn = 1'b0, enable = 1'b0;
    logic [N-1:0]      req_valid = '0, req_ready, res_valid;
    logic [N*SW-1:0]   req_data = '0;
    logic              op_din_valid, op_dout_valid, busy, tag_err, inject = 1'b0;
    logic [SW-1:0]     op_din_data;
    logic [PW-1:0]     op_dout_data, res_data;
    logic [1:0]        res_ch;
    logic              stat_clr = 1'b0;
`ifdef AVG_ARB_STATS_EN
    logic [N*16-1:0]   stat_cnt;
`endif

    avg_op_arbiter #(.NUM_CH(N), .PIXEL_WIDTH(PW), .SUM_WIDTH(SW), .MAX_BURST(MB), .PIPE_LAT(LAT)) dut (
        .clk(clk), .arstn(arstn), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .op_din_valid(op_din_valid), .op_din_data(op_din_data),
        .op_dout_valid(op_dout_valid), .op_dout_data(op_dout_data),
        .res_valid(res_valid), .res_data(res_data), .res_ch(res_ch),
`ifdef AVG_ARB_STATS_EN
        .stat_clr(stat_clr), .stat_cnt(stat_cnt),
`endif
        .busy(busy), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    // Stub datapath: echoes the low pixel bits after LAT cycles; inject forces a spurious valid.
    logic [LAT-1:0]         sv;
    logic [LAT-1:0][PW-1:0] sd;
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sv <= '0;
            sd <= '0;
        end else begin
            sv <= {sv[LAT-2:0], op_din_valid};
            sd <= {sd[LAT-2:0], op_din_data[PW-1:0]};
        end
    end
    assign op_dout_valid = sv[LAT-1] | inject;
    assign op_dout_data  = sd[LAT-1];

    typedef struct {int due; int ch; int data;} exp_t;

    int   src[N][$];
    bit   hold[N];
    bit   en_w = 1'b1, inj_w = 1'b0, clr_w = 1'b0;
    int   own = -1, ptr = 0, cnt = 0, cyc = 0, acc_total = 0;
    bit   merr = 1'b0;
    exp_t pend[$];
    int   mstat[N];
    int   acc_log[$], acc_cyc[$], res_ch_log[$], res_dat_log[$];
    int   n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_logs();
        acc_log.delete();
        acc_cyc.delete();
        res_ch_log.delete();
        res_dat_log.delete();
    endtask

    // One clock: drive at negedge, check settled outputs, then advance the model to the next edge.
    task automatic step();
        bit acc, due_now, vld_own;
        int pick;
        @(negedge clk);
        enable   = en_w;
        inject   = inj_w;
        stat_clr = clr_w;
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = src[i].size() > 0 && !hold[i];
            req_data[i*SW +: SW] = src[i].size() > 0 ? SW'(src[i][0]) : '0;
        end
        #1;
        acc     = own >= 0 && enable && req_valid[own];
        vld_own = own >= 0 && req_valid[own];
        due_now = pend.size() > 0 && pend[0].due == cyc;
        chk("req_ready", 32'(req_ready), (own >= 0 && enable) ? 32'(1 << own) : 0);
        chk("din_valid", 32'(op_din_valid), 32'(acc));
        if (acc) chk("din_data", 32'(op_din_data), 32'(src[own][0]));
        chk("res_valid", 32'(res_valid), due_now ? 32'(1 << pend[0].ch) : 0);
        if (due_now) begin
            chk("res_data", 32'(res_data), 32'(pend[0].data));
            chk("res_ch", 32'(res_ch), 32'(pend[0].ch));
        end
        chk("busy", 32'(busy), 32'(own >= 0 || pend.size() > 0));
        chk("tag_err", 32'(tag_err), 32'(merr));
        if (op_din_valid)
            for (int i = 0; i < N; i++) if (req_ready[i]) begin acc_log.push_back(i); acc_cyc.push_back(cyc); end
        if (|res_valid) begin res_ch_log.push_back(int'(res_ch)); res_dat_log.push_back(int'(res_data)); end
        merr = merr | (inject && !due_now);
        if (due_now) void'(pend.pop_front());
        if (clr_w) for (int i = 0; i < N; i++) mstat[i] = 0;
        else if (acc) mstat[own]++;
        if (own < 0) begin
            pick = -1;
            for (int k = 0; k < N; k++) if (pick < 0 && req_valid[(ptr + k) % N]) pick = (ptr + k) % N;
            if (enable && pick >= 0) begin own = pick; cnt = 0; end
        end else begin
            if (acc) begin
                pend.push_back('{cyc + LAT, own, src[own][0] & 255});
                cnt++;
                acc_total++;
                void'(src[own].pop_front());
            end
            if (!vld_own || !enable || (acc && cnt == MB)) begin ptr = (own + 1) % N; own = -1; end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 arstn = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_din_valid", 32'(op_din_valid), 0);
        chk("rst_din_data", 32'(op_din_data), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_res_ch", 32'(res_ch), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tag_err", 32'(tag_err), 0);
        for (int i = 0; i < N; i++) begin src[i].delete(); hold[i] = 1'b0; mstat[i] = 0; end
        req_valid = '0;
        inject    = 1'b0;
        own = -1; ptr = 0; cnt = 0; merr = 1'b0;
        pend.delete();
        @(negedge clk);
        #2 arstn = 1'b1;
    endtask

    initial begin
        int base;
        do_reset();

        // Single channel: three beats on ch1, results return tagged to ch1.
        clear_logs();
        src[1] = '{'h0A0, 'h0B0, 'h0C0};
        repeat (12) step();
        chk("single_cnt", 32'(res_dat_log.size()), 3);
        for (int i = 0; i < res_dat_log.size() && i < 3; i++) begin
            chk("single_ch", 32'(res_ch_log[i]), 1);
            chk("single_data", 32'(res_dat_log[i]), 32'('hA0 + 16 * i));
        end

        // Async reset with beats in flight: nothing may come back afterwards.
        for (int i = 0; i < 6; i++) src[0].push_back(int'($urandom_range(0, 4095)));
        repeat (5) step();
        do_reset();
        clear_logs();
        repeat (10) step();
        chk("post_reset_results", 32'(res_dat_log.size()), 0);

        // Burst limit with ch0 and ch2 always valid.
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            src[0].push_back(int'($urandom_range(0, 4095)));
            src[2].push_back(int'($urandom_range(0, 4095)));
        end
        repeat (40) step();
        chk("burst_cnt", 32'(acc_log.size()), 16);
        for (int i = 0; i < acc_log.size() && i < 16; i++) chk("burst_order", 32'(acc_log[i]), ((i / 4) % 2) ? 2 : 0);
        if (acc_log.size() >= 5) chk("burst_bubble", 32'(acc_cyc[4] - acc_cyc[3]), 2);

        // Wrap: pointer now sits at 3, so ch3 goes before ch0.
        clear_logs();
        src[0] = '{1, 2};
        src[3] = '{3, 4};
        repeat (15) step();
        chk("wrap_cnt", 32'(acc_log.size()), 4);
        for (int i = 0; i < acc_log.size() && i < 4; i++) chk("wrap_order", 32'(acc_log[i]), i < 2 ? 3 : 0);

        // Enable drop after two beats on ch1.
        clear_logs();
        for (int i = 0; i < 5; i++) src[1].push_back(int'($urandom_range(0, 4095)));
        base = acc_total;
        for (int k = 0; k < 20 && acc_total < base + 2; k++) step();
        en_w = 1'b0;
        repeat (6) step();
        chk("en_accepts", 32'(acc_log.size()), 2);
        chk("en_results", 32'(res_dat_log.size()), 2);
        chk("en_busy", 32'(busy), 0);
        en_w = 1'b1;
        repeat (15) step();

        // Random traffic with holds and enable glitches.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (src[i].size() < 3 && $urandom_range(0, 3) == 0) src[i].push_back(int'($urandom_range(0, 4095)));
                hold[i] = $urandom_range(0, 4) == 0;
            end
            en_w  = $urandom_range(0, 9) != 0;
            clr_w = $urandom_range(0, 99) == 0;
            step();
        end
        en_w  = 1'b1;
        clr_w = 1'b0;
        for (int i = 0; i < N; i++) hold[i] = 1'b0;
        repeat (60) step();
        for (int i = 0; i < N; i++) chk("drain_empty", 32'(src[i].size()), 0);
`ifdef AVG_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("stat_cnt", 32'(stat_cnt[i*16 +: 16]), 32'(mstat[i]));
`endif

        // Spurious datapath valid with no matching tag.
        inj_w = 1'b1;
        step();
        inj_w = 1'b0;
        repeat (3) step();
        chk("tag_err_sticky", 32'(tag_err), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/avg_op_arbiter.md
Name: avg_op_arbiter

Overview:
- Shares one averaging datapath instance (SUM_WIDTH in, PIXEL_WIDTH out, fixed 4-cycle latency) between NUM_CH requester channels, such as colour planes or tile streams.
- Round-robin arbitration with bounded bursts; each granted beat is forwarded to the datapath.
- A channel tag travels alongside each beat through a matched-latency shift register, so each result is returned to the channel that issued it.
- Sits between the line-sum stage and the per-channel output writers.

Parameters:
- NUM_CH, 4: number of requester channels; range 2..8.
- PIXEL_WIDTH, 8: result pixel width.
- SUM_WIDTH, PIXEL_WIDTH+4: width of the accumulated sum fed to the datapath.
- MAX_BURST, 16: maximum consecutive beats accepted from one grant before forced rotation; must be at least 1.
- PIPE_LAT, 4: datapath latency from op_din_valid to op_dout_valid, in cycles.

Ports:
- clk  in  1  clock
- arstn  in  1  asynchronous active-low reset
- enable  in  1  arbitration enable; low means no new grants
- req_valid  in  NUM_CH  per-channel sample valid
- req_ready  out  NUM_CH  per-channel accept; one-hot or zero
- req_data  in  NUM_CH*SUM_WIDTH  flattened sums; channel i occupies bits [i*SUM_WIDTH +: SUM_WIDTH]
- op_din_valid  out  1  to datapath
- op_din_data  out  SUM_WIDTH  to datapath
- op_dout_valid  in  1  from datapath
- op_dout_data  in  PIXEL_WIDTH  from datapath
- res_valid  out  NUM_CH  one-hot result strobe
- res_data  out  PIXEL_WIDTH  result, shared across channels
- res_ch  out  clog2(NUM_CH)  channel index of the current result
- busy  out  1  FSM in GRANT or tag pipeline non-empty
- tag_err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset: arstn low clears all state asynchronously. The FSM goes to IDLE, rr_ptr=0, grant=0, burst_cnt=0, and the tag pipe is cleared.
  - All outputs are 0 during reset.
  - Reset mid-burst drops all in-flight beats; the datapath shares the same reset.
- FSM states are IDLE and GRANT.
- IDLE:
  - If enable=1 and any req_valid bit is set, register grant = the first set channel searching from rr_ptr upward, with wrap.
  - Clear burst_cnt and move to GRANT.
  - This costs one bubble cycle; req_ready=0 in IDLE.
- GRANT:
  - req_ready[grant] = enable. All other ready bits are 0.
  - Accept = req_valid[grant] & req_ready[grant]. On accept:
    - op_din_valid=1 and op_din_data=req_data[grant], both combinational in the same cycle.
    - burst_cnt increments.
  - Exit to IDLE, setting rr_ptr = (grant+1) mod NUM_CH, when any of these holds:
    - req_valid[grant]=0, or
    - enable=0, or
    - an accept occurs while burst_cnt==MAX_BURST-1.
  - No exit happens on an accept that leaves burst_cnt below MAX_BURST-1 while req_valid stays high.
- Fairness: a channel requesting continuously never waits longer than (NUM_CH-1)*(MAX_BURST+1) cycles plus 1.
- op_din_valid=0 whenever there is no accept; op_din_data then holds its last value.
- Tag pipe:
  - PIPE_LAT stages of {valid, channel}; stage 0 is loaded with {accept, grant}.
  - It shifts every cycle and never stalls, since the datapath has no backpressure.
- Result routing:
  - When op_dout_valid=1: res_valid = onehot(tag_out.channel), res_data = op_dout_data, res_ch = tag_out.channel. These are combinational with zero added latency.
  - End-to-end latency from accept to res_valid is PIPE_LAT cycles.
- Tag errors: tag_err is set if op_dout_valid differs from tag_out.valid in any cycle. On a mismatch, res_valid is forced to 0.
- Simultaneous events:
  - enable falling in the same cycle as a valid beat: that beat is not accepted (ready=0).
  - In-flight results continue to drain while enable=0.
- Width rules: no arithmetic on data; data passes through unchanged. burst_cnt is clog2(MAX_BURST+1) bits wide.

Optional Feature:
- Macro: AVG_ARB_STATS_EN.
- When defined, adds a per-channel 16-bit saturating counter of accepted beats.
  - Extra ports: stat_clr (in, 1) and stat_cnt (out, NUM_CH*16).
  - stat_clr=1 zeroes all counters on the next edge. A simultaneous accept is not counted.
  - Counters reset to 0 and saturate at 0xFFFF.
- When undefined, these ports and the counter logic do not exist.

Decomposition:
- Shared package avg_pkg holds:
  - the constants AVG_PIPE_LAT=4 and AVG_SUM_EXTRA=4;
  - the typedef of the FSM state enum {IDLE, GRANT};
  - a function clog2 helper.
- One natural sub-module, avg_rr_pick: a combinational round-robin first-set search taking req and ptr and producing idx and any.
- The tag pipe stays inline.

Test Plan:
- Single channel: ch1 sends 3 beats of 0x0A0, 0x0B0, 0x0C0; a stub datapath with 4-cycle latency echoes the value[7:0]. Expect res_valid=4'b0010 exactly 4 cycles after each accept with data 0xA0, 0xB0, 0xC0; tag_err=0.
- Burst limit: MAX_BURST=4, ch0 and ch2 both always valid. Expect accept order ch0 x4, one bubble, ch2 x4, bubble, ch0 x4; rr_ptr ends at 1 after ch0's burst.
- Round-robin wrap: rr_ptr=3 with only ch0 and ch3 valid. Expect ch3 granted first, then ch0.
- enable drop: enable goes low mid-burst on ch1 after 2 beats. Expect req_ready=0 that cycle, FSM to IDLE, 2 results still delivered, busy=0 after 4 more cycles.
- Async reset: arstn pulses low with 3 beats in flight. Expect all outputs 0 immediately, no res_valid afterward, rr_ptr=0.
- Tag error: the stub injects op_dout_valid=1 with no accept 4 cycles earlier. Expect tag_err=1 and held, res_valid=0 that cycle. With AVG_ARB_STATS_EN, stat_cnt matches the accepted-beat totals.
